// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 write-back register file with write-through read bypass,
// optional hard-wired zero register and a commit counter/last-write tracker.
`timescale 1ns/1ps

module wb_regfile #(
   parameter bit          ZERO_LOCK = 1'b1,
   parameter int unsigned CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             WB_MemtoReg,
   input  logic             WB_RegWrite,
   input  logic [31:0]      WB_dm_out,
   input  logic [31:0]      WB_AluOut,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs_addr,
   input  logic [4:0]       rt_addr,
   output logic [31:0]      rs_data,
   output logic [31:0]      rt_data,
   output logic [31:0]      wb_data,
   output logic [CNT_W-1:0] commit_cnt,
   output logic [4:0]       last_rd,
   output logic [31:0]      last_data
);

   logic [31:0] regs [32];
   logic        wr_eff;

   // Write-back source mux feeds both storage and the bypass path.
   assign wb_data = WB_MemtoReg ? WB_dm_out : WB_AluOut;

   // A write to r0 is dropped entirely (no count) when r0 is hard-wired.
   assign wr_eff = WB_RegWrite && !(ZERO_LOCK && (rd == 5'd0));

   // rs read port: reset forces 0, locked r0 reads 0, otherwise bypass or array.
   always_comb begin
      // NOTE: the unconditional default first keeps this block free of latches.
      rs_data = regs[rs_addr];
      if (rst || (ZERO_LOCK && (rs_addr == 5'd0))) begin
         rs_data = '0;
      end else if (wr_eff && (rd == rs_addr)) begin
         rs_data = wb_data;
      end
   end

   // rt read port: same rules as rs, bypassing independently.
   always_comb begin
      rt_data = regs[rt_addr];
      if (rst || (ZERO_LOCK && (rt_addr == 5'd0))) begin
         rt_data = '0;
      end else if (wr_eff && (rd == rt_addr)) begin
         rt_data = wb_data;
      end
   end

   // Storage, commit counter and last-write tracking; reset wins over any write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the array sits in flops rather than RAM because every entry
         // must clear asynchronously; a RAM macro could not honour that.
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
         commit_cnt <= '0;
         last_rd    <= '0;
         last_data  <= '0;
      end else if (wr_eff) begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         regs[rd]   <= wb_data;
         commit_cnt <= commit_cnt + CNT_W'(1);
         last_rd    <= rd;
         last_data  <= wb_data;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed table vectors, reset/wrap sequences and randomized
// traffic checked against an array-based reference model of two instances
// (default parameters, and ZERO_LOCK=0 with a 4-bit counter).
`timescale 1ns/1ps

module tb_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        mtr, rw;
   logic [31:0] dm, alu;
   logic [4:0]  rd, rs_a, rt_a;

   logic [31:0] rs_data, rt_data, wb_data, last_data;
   logic [31:0] commit_cnt;
   logic [4:0]  last_rd;
   logic [31:0] rs_data4, rt_data4, wb_data4, last_data4;
   logic [3:0]  commit_cnt4;
   logic [4:0]  last_rd4;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk(clk), .rst(rst), .WB_MemtoReg(mtr), .WB_RegWrite(rw),
      .WB_dm_out(dm), .WB_AluOut(alu), .rd(rd), .rs_addr(rs_a), .rt_addr(rt_a),
      .rs_data(rs_data), .rt_data(rt_data), .wb_data(wb_data),
      .commit_cnt(commit_cnt), .last_rd(last_rd), .last_data(last_data)
   );

   wb_regfile #(.ZERO_LOCK(1'b0), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .WB_MemtoReg(mtr), .WB_RegWrite(rw),
      .WB_dm_out(dm), .WB_AluOut(alu), .rd(rd), .rs_addr(rs_a), .rt_addr(rt_a),
      .rs_data(rs_data4), .rt_data(rt_data4), .wb_data(wb_data4),
      .commit_cnt(commit_cnt4), .last_rd(last_rd4), .last_data(last_data4)
   );

   // Reference model: index 0 = default instance, index 1 = ZERO_LOCK=0, CNT_W=4.
   logic [31:0] mreg  [2][32];
   logic [31:0] mcnt  [2];
   logic [4:0]  mlrd  [2];
   logic [31:0] mldat [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_wb();
      return mtr ? dm : alu;
   endfunction

   function automatic logic m_eff(input int k);
      return rw && !((k == 0) && (rd == 5'd0));
   endfunction

   function automatic logic [31:0] m_read(input int k, input logic [4:0] a);
      if (rst) return 32'h0;
      if ((k == 0) && (a == 5'd0)) return 32'h0;
      if (m_eff(k) && (rd == a)) return m_wb();
      return mreg[k][a];
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 32; i++) mreg[k][i] = 32'h0;
         mcnt[k]  = 32'h0;
         mlrd[k]  = 5'h0;
         mldat[k] = 32'h0;
      end
   endtask

   task automatic m_commit();
      for (int k = 0; k < 2; k++) begin
         if (m_eff(k)) begin
            mreg[k][rd] = m_wb();
            mcnt[k]     = (mcnt[k] + 32'd1) & ((k == 1) ? 32'h0000_000F : 32'hFFFF_FFFF);
            mlrd[k]     = rd;
            mldat[k]    = m_wb();
         end
      end
   endtask

   task automatic check_comb();
      if (!$isunknown(m_wb())) begin
         check("wb_data", wb_data, m_wb());
         check("wb_data4", wb_data4, m_wb());
      end
      check("rs_data", rs_data, m_read(0, rs_a));
      check("rt_data", rt_data, m_read(0, rt_a));
      check("rs_data4", rs_data4, m_read(1, rs_a));
      check("rt_data4", rt_data4, m_read(1, rt_a));
   endtask

   task automatic check_state();
      check("commit_cnt", commit_cnt, mcnt[0]);
      check("last_rd", last_rd, mlrd[0]);
      check("last_data", last_data, mldat[0]);
      check("commit_cnt4", commit_cnt4, mcnt[1]);
      check("last_rd4", last_rd4, mlrd[1]);
      check("last_data4", last_data4, mldat[1]);
   endtask

   // Entered between a rising edge and the following falling edge.
   task automatic run_cycle();
      @(negedge clk);
      check_comb();
      @(posedge clk);
      m_commit();
      #1;
      check_state();
   endtask

   typedef struct {
      logic        mtr, rw;
      logic [31:0] dm, alu;
      logic [4:0]  rd, rs, rt;
      logic [31:0] e_rs, e_rt, e_wb, e_cnt;
      logic [4:0]  e_lrd;
      logic [31:0] e_ldat;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      //             mtr   rw    dm            alu           rd     rs     rt     e_rs          e_rt          e_wb          e_cnt  e_lrd  e_ldat
      tbl[0] = '{1'b0, 1'b1, 32'h0,        32'h1234_5678, 5'd5, 5'd5, 5'd0, 32'h1234_5678, 32'h0,        32'h1234_5678, 32'd1, 5'd5, 32'h1234_5678};
      tbl[1] = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd5, 5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678, 32'h0,        32'd1, 5'd5, 32'h1234_5678};
      tbl[2] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0,        5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd2, 5'd9, 32'hDEAD_BEEF};
      tbl[3] = '{1'b0, 1'b0, 32'h0,        32'h0,         5'd0, 5'd9, 5'd5, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0,        32'd2, 5'd9, 32'hDEAD_BEEF};
      tbl[4] = '{1'b0, 1'b1, 32'h0,        32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'hFFFF_FFFF, 32'd2, 5'd9, 32'hDEAD_BEEF};
      tbl[5] = '{1'b0, 1'b0, 32'h0,        32'hAAAA_AAAA, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,        32'hAAAA_AAAA, 32'd2, 5'd9, 32'hDEAD_BEEF};
      tbl[6] = '{1'b0, 1'b1, 32'h0,        32'h0000_0033, 5'd3, 5'd3, 5'd9, 32'h0000_0033, 32'hDEAD_BEEF, 32'h0000_0033, 32'd3, 5'd3, 32'h0000_0033};
      tbl[7] = '{1'b0, 1'b0, 32'h0,        32'hAAAA_AAAA, 5'd3, 5'd3, 5'd0, 32'h0000_0033, 32'h0,        32'hAAAA_AAAA, 32'd3, 5'd3, 32'h0000_0033};

      // Reset with an enabled write pending: nothing may commit or bypass.
      rst = 1'b1; mtr = 1'b0; rw = 1'b1; dm = 32'h0; alu = 32'h0000_0044;
      rd = 5'd4; rs_a = 5'd4; rt_a = 5'd4;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_rs_no_bypass", rs_data, 32'h0);
      check("rst_rt_no_bypass", rt_data4, 32'h0);
      check("rst_commit_cnt", commit_cnt, 32'h0);
      check("rst_last_rd", last_rd, 5'h0);
      check("rst_last_data", last_data, 32'h0);
      @(negedge clk);
      rst = 1'b0; rw = 1'b0;
      @(posedge clk);
      #1;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         mtr = tbl[i].mtr; rw = tbl[i].rw; dm = tbl[i].dm; alu = tbl[i].alu;
         rd = tbl[i].rd; rs_a = tbl[i].rs; rt_a = tbl[i].rt;
         @(negedge clk);
         check($sformatf("vec%0d_rs", i), rs_data, tbl[i].e_rs);
         check($sformatf("vec%0d_rt", i), rt_data, tbl[i].e_rt);
         check($sformatf("vec%0d_wb", i), wb_data, tbl[i].e_wb);
         check_comb();
         @(posedge clk);
         m_commit();
         #1;
         check($sformatf("vec%0d_cnt", i), commit_cnt, tbl[i].e_cnt);
         check($sformatf("vec%0d_last_rd", i), last_rd, tbl[i].e_lrd);
         check($sformatf("vec%0d_last_data", i), last_data, tbl[i].e_ldat);
         check_state();
      end

      // Mid-operation asynchronous reset, lost write, first write afterwards.
      mtr = 1'b0; rw = 1'b1; alu = 32'h0000_0055; rd = 5'd7; rs_a = 5'd7; rt_a = 5'd7;
      run_cycle();
      rw = 1'b0;
      #2;
      check("r7_before_rst", rs_data, 32'h0000_0055);
      rst = 1'b1;
      m_reset();
      #1;
      check("r7_async_clear", rs_data, 32'h0);
      check("cnt_async_clear", commit_cnt, 32'h0);
      check("cnt4_async_clear", commit_cnt4, 32'h0);
      check("last_data_async_clear", last_data, 32'h0);
      rw = 1'b1; alu = 32'h0000_0099;
      #1;
      check("rst_write_no_bypass", rs_data, 32'h0);
      @(posedge clk);
      #1;
      check("rst_write_lost_cnt", commit_cnt, 32'h0);
      check("rst_write_lost_r7", rt_data, 32'h0);
      #2;
      rst = 1'b0;
      run_cycle();
      check("first_after_rst_cnt", commit_cnt, 32'd1);
      check("first_after_rst_data", last_data, 32'h0000_0099);

      // 15 further effective writes: the 4-bit counter wraps to 0 at 16.
      for (int i = 1; i < 16; i++) begin
         rw = 1'b1; mtr = 1'b0; alu = $urandom; rd = 5'(i); rs_a = 5'(i); rt_a = 5'd7;
         run_cycle();
      end
      check("wrap_cnt4", commit_cnt4, 32'h0);
      check("wrap_cnt32", commit_cnt, 32'd16);

      // Randomized traffic, including unknown data while the write is disabled.
      for (int n = 0; n < 400; n++) begin
         rw   = ($urandom_range(0, 3) != 0);
         mtr  = 1'($urandom_range(0, 1));
         dm   = $urandom;
         alu  = $urandom;
         rd   = 5'($urandom_range(0, 31));
         rs_a = ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31));
         rt_a = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
         if (!rw && ($urandom_range(0, 3) == 0)) begin
            dm  = 'x;
            alu = 'x;
         end
         run_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter ZERO_LOCK, default 1: when 1, register 0 ignores writes and reads as 32'h0.
REQ-002 Parameter CNT_W, default 32: width of the commit counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 WB_MemtoReg  input  1  write-back source select: 1 selects WB_dm_out, 0 selects WB_AluOut.
REQ-006 WB_RegWrite  input  1  write enable from the MEM/WB pipeline register; already 0 for faulted instructions.
REQ-007 WB_dm_out  input  32  data-memory load result.
REQ-008 WB_AluOut  input  32  ALU result.
REQ-009 rd  input  5  destination register index.
REQ-010 rs_addr, rt_addr  input  5 each  decode-stage read addresses.
REQ-011 rs_data, rt_data  output  32 each  read data after bypass.
REQ-012 wb_data  output  32  selected write-back value (combinational).
REQ-013 commit_cnt  output  CNT_W  number of register writes committed since reset.
REQ-014 last_rd  output  5  index of the most recent committed write.
REQ-015 last_data  output  32  value of the most recent committed write.

Function
REQ-016 wb_data SHALL equal WB_MemtoReg ? WB_dm_out : WB_AluOut, with zero latency.
REQ-017 Storage SHALL be 32 registers of 32 bits each.
REQ-018 A write is "effective" when WB_RegWrite=1, and not (ZERO_LOCK=1 and rd=0).
REQ-019 On a rising clk edge with an effective write, register[rd] SHALL take wb_data.
REQ-020 On that same edge, commit_cnt SHALL increment by 1, last_rd SHALL take rd, and last_data SHALL take wb_data.
REQ-021 commit_cnt SHALL wrap from all-ones to 0 with no flag.
REQ-022 When the write is not effective, no register, counter, last_rd or last_data SHALL change.
REQ-023 Reads SHALL be combinational: rs_data = register[rs_addr] and rt_data = register[rt_addr].
REQ-024 Bypass: when a write is effective and rd equals a read address, that read port SHALL return wb_data in the same cycle (write-through, no one-cycle stale read).
REQ-025 Both ports SHALL bypass independently; rs_addr = rt_addr = rd SHALL give wb_data on both.
REQ-026 With ZERO_LOCK=1, a read of address 0 SHALL return 0 regardless of bypass conditions.
REQ-027 With ZERO_LOCK=0, register 0 SHALL behave as a normal register.
REQ-028 X on WB_dm_out or WB_AluOut while WB_RegWrite=0 SHALL NOT corrupt state.

Reset
REQ-029 rst=1 SHALL asynchronously clear all 32 registers, commit_cnt, last_rd and last_data to 0, without waiting for a clock edge.
REQ-030 While rst=1, writes SHALL be ignored.
REQ-031 Read ports SHALL return 0 during reset, with no bypass of wb_data.
REQ-032 If rst asserts on the same cycle as an effective write, the write SHALL be lost.
REQ-033 After rst deasserts, the first rising edge with an effective write SHALL commit normally and set commit_cnt to 1.

Verification
REQ-034 ALU write: WB_RegWrite=1, WB_MemtoReg=0, WB_AluOut=32'h1234_5678, rd=5, then next cycle rs_addr=5 -> rs_data=32'h1234_5678, commit_cnt=1, last_rd=5.
REQ-035 Load write with same-cycle bypass: WB_MemtoReg=1, WB_dm_out=32'hDEAD_BEEF, rd=9, rs_addr=rt_addr=9 in the write cycle -> rs_data=rt_data=32'hDEAD_BEEF before the edge, and register 9 holds the same value after the edge.
REQ-036 Zero lock: ZERO_LOCK=1, WB_RegWrite=1, rd=0, WB_AluOut=32'hFFFF_FFFF -> rs_addr=0 reads 0 and commit_cnt is unchanged.
REQ-037 Suppressed write: WB_RegWrite=0, rd=3, WB_AluOut=32'hAAAA_AAAA -> register 3 keeps its prior value and commit_cnt, last_rd, last_data are unchanged.
REQ-038 Mid-operation reset: write 32'h55 to r7, pulse rst asynchronously between clock edges -> rs_data for r7 and commit_cnt drop to 0 immediately.
REQ-039 Counter wrap: CNT_W=4 with 16 effective writes -> commit_cnt returns to 0.
